pin_array_deser: RTL and testbench
==================================

# pin_array_deser

Serial-to-parallel converter for the pin-array bus: receives one bit per qualified clock on `vin` and assembles `WIDTH`-bit words on `vout`. It is the receiving end of the path that merges the `mid[3:0]` bus onto a single `vout` line, and restores that bus at the far side. Output words use a valid/ready handshake with a one-word holding register. Overflow is reported through a sticky flag.

## Interface
- `WIDTH`, 4: word width in bits; legal range 2..32.
- `MSB_FIRST`, 0: 0 = first received bit lands in `vout[0]`; 1 = first received bit lands in `vout[WIDTH-1]`.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `VDD`  input  1  supply pin; no logic function.
- `VSS`  input  1  supply pin; no logic function.
- `vin`  input  1  serial data bit.
- `vin_valid`  input  1  qualifies `vin` for this cycle.
- `sync`  input  1  with `vin_valid`, marks `vin` as bit 0 of a new word.
- `vout`  output  WIDTH  assembled word.
- `vout_valid`  output  1  `vout` holds an unconsumed word.
- `vout_ready`  input  1  consumer accepts `vout` this cycle.
- `ovf`  output  1  sticky overflow flag.
- `clr_ovf`  input  1  clears `ovf`.

## Operation
- State:
  - shift register `shreg[WIDTH-1:0]`
  - bit counter `cnt`, width $clog2(WIDTH), range 0..WIDTH-1
  - output register `vout` and `vout_valid`
  - `ovf`
- Bit placement: with `MSB_FIRST`=0, the bit with counter value `cnt` is written to `shreg[cnt]`. With `MSB_FIRST`=1, it is written to `shreg[WIDTH-1-cnt]`.
- `vin_valid`=0: `shreg` and `cnt` hold.
- `vin_valid`=1 and `sync`=1:
  - Any partial word is discarded.
  - `vin` is stored as bit 0 and `cnt` becomes 1.
  - For WIDTH≥2 this never completes a word.
- `vin_valid`=1, `sync`=0, `cnt`<WIDTH-1: store the bit and increment `cnt`.
- `vin_valid`=1, `sync`=0, `cnt`=WIDTH-1: the word is complete and `cnt` wraps to 0.
  - If the output slot is free, the complete word (including this bit) loads into `vout` and `vout_valid` is set. The slot is free when `vout_valid`=0, or when `vout_valid`=1 and `vout_ready`=1 in the same cycle.
  - If the slot is not free, the word is dropped, `ovf` is set, and `vout` and `vout_valid` are unchanged.
- Handshake:
  - A transfer occurs on any edge where `vout_valid` and `vout_ready` are both 1.
  - `vout_valid` deasserts after a transfer unless a new word loads on the same edge.
  - `vout` is stable while `vout_valid`=1 and no transfer occurs.
  - `vout_ready` while `vout_valid`=0 has no effect.
- `ovf`: set on any dropped word. Cleared by `clr_ovf`=1. If set and clear occur on the same edge, set wins.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream): `shreg`=0, `cnt`=0, `vout`=0, `vout_valid`=0, `ovf`=0. Reset mid-word discards the partial word.
- Latency: last bit sampled at edge N, so `vout`/`vout_valid` are valid after edge N, i.e. one cycle.
- Throughput: one word per WIDTH qualified cycles. With `vout_ready` held at 1 there is no overflow at full rate, including back-to-back words.
- Word complete and transfer on the same edge: the new word replaces the old one, `vout_valid` stays 1, and `ovf` is unchanged.
- `sync` with `vin_valid`=0 is ignored.

## Structure
- Package `pin_array_pkg`:
  - `PIN_ARRAY_WIDTH` = 4 (default for `WIDTH`)
  - counter-width localparam helper
  - shared bit-order enum (`LSB_FIRST`, `MSB_FIRST`), also used by the serializer side
- One sub-module, `pin_array_outreg`: the one-word valid/ready holding register. It takes `load`/`data` and produces `vout`/`vout_valid`/`busy`.
- Bit counting, shift logic and the overflow flag live in the top module.

## Test plan
- Reset, then feed bits 1,0,1,1 (LSB first, `MSB_FIRST`=0, `vout_ready`=1) → `vout`=4'b1101 with `vout_valid` for 1 cycle, one cycle after the 4th bit.
- Same stream with `MSB_FIRST`=1 → `vout`=4'b1011.
- Feed 2 bits, then assert `sync` with bits 0,0,1,0 → `vout`=4'b0100; the partial word is discarded and `ovf`=0.
- `vout_ready`=0, send words 0x3 then 0x5 → `vout` stays 0x3 and `ovf`=1. Then `vout_ready`=1 → 0x3 transfers and `vout_valid`=0.
- Continuous words 0xA,0x5,0xF with `vout_ready` asserted only on the completion edges → every word is delivered, `vout_valid` never drops between words, and `ovf`=0.
- `rst_n` low for 1 cycle after 3 bits, then 4 bits 1,1,1,1 → `vout`=4'hF; no stale bits appear.

Source files
------------

// File: rtl/pin_array_deser_pkg.sv
// Shared definitions for the pin-array serial path (deserializer and serializer).
//   PIN_ARRAY_WIDTH : default word width of the pin-array bus
//   bit_order_e     : order in which word bits travel on the serial line
//   cnt_width()     : width of a bit counter that spans 0..w-1 (at least 1 bit)
package pin_array_pkg;

    localparam int PIN_ARRAY_WIDTH = 32'd4;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    function automatic int cnt_width(input int w);
        if (w > 32'd1) begin
            return $clog2(w);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/pin_array_deser_if.sv
// Serial-in / word-out bundle of the pin-array deserializer.
//   vin, vin_valid, sync    : serial bit, its qualifier and the start-of-word marker
//   vout, vout_valid        : assembled word and its valid flag
//   vout_ready              : consumer accepts vout this cycle
// The slave modport is the deserializer; the master modport is the environment
// that feeds serial bits in and consumes words out.
interface pin_array_deser_if #(
    parameter int WIDTH = 32'd4
);
    logic             vin;
    logic             vin_valid;
    logic             sync;
    logic [WIDTH-1:0] vout;
    logic             vout_valid;
    logic             vout_ready;

    modport slave (
        input  vin,
        input  vin_valid,
        input  sync,
        input  vout_ready,
        output vout,
        output vout_valid
    );

    modport master (
        output vin,
        output vin_valid,
        output sync,
        output vout_ready,
        input  vout,
        input  vout_valid
    );
endinterface

// File: rtl/pin_array_outreg.sv
// One-word valid/ready holding register for assembled words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load, data  : store data as the new output word this edge
//   ready       : consumer accepts vout this cycle
//   vout        : held word, stable while vout_valid=1 and no transfer occurs
//   vout_valid  : vout holds an unconsumed word
//   busy        : slot cannot take a word this edge (held and not being consumed)
module pin_array_outreg #(
    parameter int WIDTH = 32'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] vout,
    output logic             vout_valid,
    output logic             busy
);

    // A word sitting in the slot that nobody takes this cycle blocks a new load.
    assign busy = vout_valid & ~ready;

    // Word slot: a load overrides a concurrent transfer, so valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vout       <= {WIDTH{1'b0}};
            vout_valid <= 1'b0;
        end else if (load) begin
            vout       <= data;
            vout_valid <= 1'b1;
        end else if (vout_valid && ready) begin
            vout_valid <= 1'b0;
        end else begin
            vout_valid <= vout_valid;
        end
    end

endmodule

// File: rtl/pin_array_deser.sv
// Serial-to-parallel converter restoring the pin-array bus from one serial line.
//   clk, rst_n  : clock, asynchronous active-low reset
//   VDD, VSS    : supply pins, no logic function
//   bus (slave) : vin/vin_valid/sync serial input, vout/vout_valid/vout_ready word output
//   ovf         : sticky flag, set whenever a complete word finds the slot occupied
//   clr_ovf     : clears ovf (a simultaneous overflow wins)
// MSB_FIRST=0 places the first received bit in vout[0], MSB_FIRST=1 in vout[WIDTH-1].
module pin_array_deser #(
    parameter int WIDTH     = pin_array_pkg::PIN_ARRAY_WIDTH,
    parameter int MSB_FIRST = 32'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               VDD,
    input  logic               VSS,
    pin_array_deser_if.slave   bus,
    output logic               ovf,
    input  logic               clr_ovf
);
    import pin_array_pkg::*;

    localparam int              CW       = cnt_width(WIDTH);
    localparam bit_order_e      ORDER    = (MSB_FIRST != 32'd0) ? pin_array_pkg::MSB_FIRST
                                                                : pin_array_pkg::LSB_FIRST;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 32'd1);
    // Position of the first bit of a word, used when sync restarts assembly.
    localparam logic [CW-1:0]   SYNC_IDX = (ORDER == pin_array_pkg::MSB_FIRST) ? CNT_LAST
                                                                                : {CW{1'b0}};

    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    idx_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] sync_word_s;
    logic             last_s;
    logic             load_s;
    logic             drop_s;
    logic             busy_s;
    logic             unused_supply_s;

    assign unused_supply_s = VDD ^ VSS;

    // Translate the bit counter into a shreg position for the chosen bit order.
    always_comb begin
        idx_s = cnt_r;
        if (ORDER == pin_array_pkg::MSB_FIRST) begin
            idx_s = CNT_LAST - cnt_r;
        end else begin
            idx_s = cnt_r;
        end
    end

    // Candidate shift-register contents: continue the word, or restart it on sync.
    always_comb begin
        word_s             = shreg_r;
        word_s[idx_s]      = bus.vin;
        sync_word_s        = {WIDTH{1'b0}};
        sync_word_s[SYNC_IDX] = bus.vin;
    end

    // sync always restarts at bit 0, so with WIDTH>=2 it can never finish a word.
    assign last_s = bus.vin_valid & ~bus.sync & (cnt_r == CNT_LAST);
    assign load_s = last_s & ~busy_s;
    assign drop_s = last_s &  busy_s;

    // Bit counter and shift register; partial words are wiped by sync or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (bus.vin_valid) begin
            if (bus.sync) begin
                shreg_r <= sync_word_s;
                cnt_r   <= CW'(32'd1);
            end else if (cnt_r == CNT_LAST) begin
                shreg_r <= word_s;
                cnt_r   <= {CW{1'b0}};
            end else begin
                shreg_r <= word_s;
                cnt_r   <= cnt_r + CW'(32'd1);
            end
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
        end
    end

    // Sticky overflow: a dropped word takes priority over a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop_s) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf;
        end
    end

    // The completed word includes the bit arriving this cycle (word_s, not shreg_r).
    pin_array_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .data       (word_s),
        .ready      (bus.vout_ready),
        .vout       (bus.vout),
        .vout_valid (bus.vout_valid),
        .busy       (busy_s)
    );

endmodule

// File: tb/tb_pin_array_deser.sv
// Directed bench for pin_array_deser: one LSB-first and one MSB-first instance
// receive the same serial stream; expected words are hand-computed constants.
module tb_pin_array_deser;

    logic clk;
    logic rst_n;
    logic vin;
    logic vin_valid;
    logic sync;
    logic vout_ready;
    logic clr_ovf;
    logic ovf_l;
    logic ovf_m;
    logic vdd;
    logic vss;
    int   errors;
    int   checks;

    pin_array_deser_if #(.WIDTH(4)) bus_l ();
    pin_array_deser_if #(.WIDTH(4)) bus_m ();

    assign bus_l.vin        = vin;
    assign bus_l.vin_valid  = vin_valid;
    assign bus_l.sync       = sync;
    assign bus_l.vout_ready = vout_ready;
    assign bus_m.vin        = vin;
    assign bus_m.vin_valid  = vin_valid;
    assign bus_m.sync       = sync;
    assign bus_m.vout_ready = vout_ready;

    pin_array_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .VDD     (vdd),
        .VSS     (vss),
        .bus     (bus_l),
        .ovf     (ovf_l),
        .clr_ovf (clr_ovf)
    );

    pin_array_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk     (clk),
        .rst_n   (rst_n),
        .VDD     (vdd),
        .VSS     (vss),
        .bus     (bus_m),
        .ovf     (ovf_m),
        .clr_ovf (clr_ovf)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one qualified bit, let the next rising edge take it, sample 1 after.
    task automatic send(input logic b, input logic s);
        vin       = b;
        vin_valid = 1'b1;
        sync      = s;
        @(posedge clk);
        #1;
        vin_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] words [3];
        logic [3:0] w;
        errors     = 0;
        checks     = 0;
        vdd        = 1'b1;
        vss        = 1'b0;
        rst_n      = 1'b0;
        vin        = 1'b0;
        vin_valid  = 1'b0;
        sync       = 1'b0;
        vout_ready = 1'b1;
        clr_ovf    = 1'b0;
        idle();
        idle();
        chk("reset_vout",  {28'd0, bus_l.vout},       32'h0);
        chk("reset_valid", {31'd0, bus_l.vout_valid}, 32'h0);
        chk("reset_ovf",   {31'd0, ovf_l},            32'h0);
        rst_n = 1'b1;
        idle();

        // Stream 1,0,1,1: LSB-first gives 1101, MSB-first gives 1011.
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("t1_valid_before", {31'd0, bus_l.vout_valid}, 32'h0);
        send(1'b1, 1'b0);
        chk("t1_vout_lsb",  {28'd0, bus_l.vout},       32'hD);
        chk("t1_valid_lsb", {31'd0, bus_l.vout_valid}, 32'h1);
        chk("t1_vout_msb",  {28'd0, bus_m.vout},       32'hB);
        idle();
        chk("t1_valid_drop", {31'd0, bus_l.vout_valid}, 32'h0);

        // Two stray bits, then sync restarts with 0,0,1,0 -> 0100 / 0010.
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("t2_valid_before", {31'd0, bus_l.vout_valid}, 32'h0);
        send(1'b0, 1'b0);
        chk("t2_vout_lsb", {28'd0, bus_l.vout}, 32'h4);
        chk("t2_vout_msb", {28'd0, bus_m.vout}, 32'h2);
        chk("t2_ovf",      {31'd0, ovf_l},      32'h0);
        idle();

        // Consumer stalled: 0x3 is held, 0x5 is dropped and flags overflow.
        vout_ready = 1'b0;
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        idle();
        chk("t3_hold_vout", {28'd0, bus_l.vout},       32'h3);
        chk("t3_ovf_clear", {31'd0, ovf_l},            32'h0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        chk("t3_vout_kept", {28'd0, bus_l.vout},       32'h3);
        chk("t3_valid",     {31'd0, bus_l.vout_valid}, 32'h1);
        chk("t3_ovf_set",   {31'd0, ovf_l},            32'h1);
        vout_ready = 1'b1;
        idle();
        chk("t3_xfer_valid", {31'd0, bus_l.vout_valid}, 32'h0);
        chk("t3_ovf_sticky", {31'd0, ovf_l},            32'h1);
        clr_ovf = 1'b1;
        idle();
        clr_ovf = 1'b0;
        chk("t3_ovf_cleared", {31'd0, ovf_l}, 32'h0);

        // Back-to-back 0xA,0x5,0xF with ready only on completion edges.
        words[0] = 4'hA;
        words[1] = 4'h5;
        words[2] = 4'hF;
        for (int i = 0; i < 12; i++) begin
            w          = words[i / 4];
            vout_ready = ((i % 4) == 3) ? 1'b1 : 1'b0;
            send(w[i % 4], 1'b0);
            if (i >= 3) begin
                chk($sformatf("t4_valid_%0d", i), {31'd0, bus_l.vout_valid}, 32'h1);
            end
            if ((i % 4) == 3) begin
                chk($sformatf("t4_word_%0d", i / 4), {28'd0, bus_l.vout}, {28'd0, w});
            end
        end
        chk("t4_ovf", {31'd0, ovf_l}, 32'h0);
        vout_ready = 1'b1;
        idle();
        chk("t4_drain", {31'd0, bus_l.vout_valid}, 32'h0);

        // Reset mid-word; the following 1,1,1,1 must assemble cleanly to 0xF.
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        send(1'b1, 1'b0);
        chk("t5_no_stale_word", {31'd0, bus_l.vout_valid}, 32'h0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("t5_vout_lsb", {28'd0, bus_l.vout},       32'hF);
        chk("t5_valid",    {31'd0, bus_l.vout_valid}, 32'h1);
        chk("t5_vout_msb", {28'd0, bus_m.vout},       32'hF);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
